// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multi-cycle sequencer and the Simple_Single_CPU datapath.
// master: sequencer side (takes instruction fields/flags/ready, drives controls).
// slave : datapath side (the reverse).
interface mc_ctrl_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode_i;
  logic [5:0]       funct_i;
  logic             zero_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             pc_write_cond_o;
  logic [1:0]       pc_src_o;
  logic             i_or_d_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             ir_write_o;
  logic             mem_to_reg_o;
  logic             reg_dst_o;
  logic             reg_write_o;
  logic             alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [1:0]       alu_op_o;
  logic [3:0]       state_o;
  logic             illegal_o;
  logic [CNT_W-1:0] instr_cnt_o;

  modport master (
    input  opcode_i, funct_i, zero_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, pc_src_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, state_o, illegal_o, instr_cnt_o
  );

  modport slave (
    output opcode_i, funct_i, zero_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, pc_src_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, state_o, illegal_o, instr_cnt_o
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the Simple_Single_CPU datapath.
// Ports: clk_i (rising edge), rst_i (synchronous, active-high), bus (master
// modport of mc_ctrl_fsm_if: opcode/funct/zero/mem_ready in; mux selects,
// write enables, state, illegal pulse and retired count out).
// Controls are registered, decoded from the next state so they line up with
// state_o. Only the write enables are further gated: the fetch-time IR/PC loads
// by the live memory ready, and every enable by rst_i so a reset cycle never writes.
module mc_ctrl_fsm #(
  parameter int unsigned USE_READY = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mc_ctrl_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BEQ       = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       fetch;          // IR/PC load, qualified by ready
    logic       pc_write;       // unconditional PC load (jump)
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  state_e           state_q;
  ctrl_t            ctrl_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rdy;
  logic             unused_inputs;

  // Without the handshake, memory is treated as always ready.
  assign rdy = (USE_READY != 0) ? bus.mem_ready_i : 1'b1;

  // funct goes to ALU control outside this block; zero is qualified in the datapath.
  assign unused_inputs = ^{bus.funct_i, bus.zero_i};

  // Next state; ready and opcode only matter in the states that sample them.
  function automatic state_e next_state(state_e s, logic r, logic [5:0] op);
    state_e n;
    n = FETCH;
    case (s)
      FETCH:     n = r ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_RTYPE:     n = R_EXEC;
          OP_LW, OP_SW: n = MEM_ADDR;
          OP_BEQ:       n = BEQ;
          OP_J:         n = JUMP;
          OP_ADDI:      n = ADDI_EXEC;
          default:      n = FETCH;
        endcase
      end
      // An opcode that is neither lw nor sw here abandons the access.
      MEM_ADDR:  n = (op == OP_LW) ? MEM_RD : ((op == OP_SW) ? MEM_WR : FETCH);
      MEM_RD:    n = r ? MEM_WB : MEM_RD;
      MEM_WR:    n = r ? FETCH : MEM_WR;
      R_EXEC:    n = R_WB;
      ADDI_EXEC: n = ADDI_WB;
      default:   n = FETCH;
    endcase
    return n;
  endfunction

  // True on the cycle whose closing edge retires an instruction.
  function automatic logic retires(state_e s, logic r);
    logic ret;
    ret = 1'b0;
    case (s)
      MEM_WB, R_WB, ADDI_WB, BEQ, JUMP: ret = 1'b1;
      MEM_WR:                           ret = r;
      default:                          ret = 1'b0;
    endcase
    return ret;
  endfunction

  function automatic logic is_legal(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  // Moore control decode.
  function automatic ctrl_t decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'd1;
      end
      DECODE:    c.alu_src_b = 2'd3;
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'd2;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      ADDI_WB:   c.reg_write = 1'b1;
      BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'd1;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 2'd1;
      end
      JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'd2;
      end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Sequencer state, registered controls, illegal pulse and retire counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      ctrl_q    <= decode(FETCH);
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= next_state(state_q, rdy, bus.opcode_i);
      ctrl_q    <= decode(next_state(state_q, rdy, bus.opcode_i));
      illegal_q <= (state_q == DECODE) && !is_legal(bus.opcode_i);
      if (retires(state_q, rdy)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.ir_write_o      = ctrl_q.fetch & rdy & ~rst_i;
  assign bus.pc_write_o      = ((ctrl_q.fetch & rdy) | ctrl_q.pc_write) & ~rst_i;
  assign bus.pc_write_cond_o = ctrl_q.pc_write_cond & ~rst_i;
  assign bus.mem_write_o     = ctrl_q.mem_write & ~rst_i;
  assign bus.reg_write_o     = ctrl_q.reg_write & ~rst_i;
  assign bus.pc_src_o        = ctrl_q.pc_src;
  assign bus.i_or_d_o        = ctrl_q.i_or_d;
  assign bus.mem_read_o      = ctrl_q.mem_read;
  assign bus.mem_to_reg_o    = ctrl_q.mem_to_reg;
  assign bus.reg_dst_o       = ctrl_q.reg_dst;
  assign bus.alu_src_a_o     = ctrl_q.alu_src_a;
  assign bus.alu_src_b_o     = ctrl_q.alu_src_b;
  assign bus.alu_op_o        = ctrl_q.alu_op;
  assign bus.state_o         = state_q;
  assign bus.illegal_o       = illegal_q;
  assign bus.instr_cnt_o     = cnt_q;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the Simple_Single_CPU datapath. It is the planned replacement for the single-cycle decoder.
- Steps each instruction through fetch/decode/execute/memory/writeback states and drives the datapath mux selects and write enables.
- Stalls on a memory ready handshake, flags unsupported opcodes, and counts retired instructions for bench-side checking.

Parameters:
- USE_READY, 1, 1 = wait on mem_ready_i in memory states; 0 = treat mem_ready_i as always 1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- opcode_i  in  6  IR[31:26], valid from DECODE onward.
- funct_i  in  6  IR[5:0]; passed to the ALU control via alu_op_o.
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory has completed the current access.
- pc_write_o  out  1  unconditional PC load.
- pc_write_cond_o  out  1  PC load when zero_i = 1 (branch).
- pc_src_o  out  2  0 = ALU result, 1 = ALUOut register, 2 = jump target.
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- ir_write_o  out  1  IR load.
- mem_to_reg_o  out  1  writeback data select: 1 = MDR, 0 = ALUOut.
- reg_dst_o  out  1  destination register: 1 = rd, 0 = rt.
- reg_write_o  out  1  register file write enable.
- alu_src_a_o  out  1  ALU A input: 0 = PC, 1 = register A.
- alu_src_b_o  out  2  ALU B input: 0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- alu_op_o  out  2  0 = add, 1 = sub, 2 = decode funct.
- state_o  out  4  current state encoding.
- illegal_o  out  1  one-cycle pulse on an unsupported opcode.
- instr_cnt_o  out  CNT_W  retired instruction count.

Behaviour:
- Reset: state = FETCH (0), instr_cnt_o = 0, illegal_o = 0.
  - Every control output holds its FETCH value, with pc_write_o and ir_write_o gated low because rst_i is high.
  - Reset mid-instruction aborts the instruction: no write enable is asserted on the reset cycle, and the count is not incremented.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BEQ=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
  - Encodings 12–15 go to FETCH on the next edge.
- Outputs are Moore-style, decoded from state. The only exceptions are the ready-gated enables listed below.
  - Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - ir_write and pc_write = mem_ready_i.
  - Stays in FETCH while mem_ready_i=0; goes to DECODE on ready.
- DECODE:
  - alu_src_a=0, alu_src_b=3, alu_op=0 (precomputes the branch target).
  - Next state by opcode: 000000 -> R_EXEC; 100011 (lw) or 101011 (sw) -> MEM_ADDR; 000100 -> BEQ; 000010 -> JUMP; 001000 -> ADDI_EXEC.
  - Any other opcode -> FETCH, with illegal_o=1 for exactly the next cycle; it does not count as retired.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Waits for ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH, retires.
- MEM_WR: mem_write=1, i_or_d=1. Waits for ready; on ready -> FETCH, retires.
  - mem_write stays high for the whole wait.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH, retires.
- ADDI_EXEC: alu_src_a=1, alu_src_b=2, alu_op=0. -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH, retires.
- BEQ: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_src=1. -> FETCH, retires.
- JUMP: pc_write=1, pc_src=2. -> FETCH, retires.
- Retire: instr_cnt_o increments by 1 on the edge that leaves a retiring state.
  - The counter wraps modulo 2^CNT_W with no saturation.
- Cycle counts with zero wait:
  - lw = 5; sw, R-type and addi = 4; beq and j = 3.
  - Each wait cycle in FETCH, MEM_RD or MEM_WR adds 1.
- Memory handshake:
  - mem_ready_i is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored in every other state.
  - When USE_READY=0, ready is forced to 1.
- opcode_i is sampled only in DECODE and MEM_ADDR. Changing it in any other state has no effect.

Test Plan:
- Reset: rst_i=1 for 2 cycles, then 0 with ready tied high -> state_o = 0,1,… and instr_cnt_o = 0 during reset.
  - During reset: pc_write_o=0, ir_write_o=0.
- R-type (opcode 000000, funct 100000), ready=1:
  - state_o sequence 0,1,6,7,0.
  - reg_write_o=1 and reg_dst_o=1 only in state 7.
  - instr_cnt_o goes 0 -> 1 after 4 cycles.
- lw (100011) with mem_ready_i low for 2 cycles in MEM_RD:
  - state_o sequence 0,1,2,3,3,3,4,0, i.e. 7 cycles.
  - i_or_d_o=1 throughout state 3.
  - mem_to_reg_o=1 in state 4.
- beq (000100):
  - With zero_i=1: pc_write_cond_o=1 and pc_src_o=1 in state 8.
  - Repeat with zero_i=0: same outputs, and count increments both times.
- Jump and illegal:
  - Opcode 000010 -> states 0,1,9,0 with pc_src_o=2.
  - Opcode 111111 -> states 0,1,0; illegal_o pulses for 1 cycle; count unchanged.
- Reset mid-sw: assert rst_i while in state 5 (MEM_WR) with ready=0.
  - mem_write_o=0 from the edge at which reset is sampled.
  - state_o=0 and instr_cnt_o unchanged-then-0.
  - Also: USE_READY=0 build with ready tied low still completes lw in 5 cycles.
